// File: rtl/shot_pkg.sv
// shot_pkg: shared types and constants for the white-ball shot front end.
//   shot_state_t  - front-end FSM state (IDLE=0, AIM=1, FIRE=2)
//   LEVEL_W       - width of the signed per-axis aim level
//   FRAME_W       - width of the unsigned frame counters
//   frame_inc_sat - saturating frame-counter increment
package shot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AIM  = 2'd1,
    FIRE = 2'd2
  } shot_state_t;

  localparam int LEVEL_W = 4;
  localparam int FRAME_W = 7;

  // Increment a frame counter, holding at 'limit' once it gets there.
  function automatic logic [FRAME_W-1:0] frame_inc_sat(
    input logic [FRAME_W-1:0] cnt,
    input logic [FRAME_W-1:0] limit
  );
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/shot_charge_ctrl_key_repeat.sv
// key_repeat: edge detect plus auto-repeat for one arrow key.
// Ports:
//   clk, resetN   - clock, asynchronous active-low reset
//   enable        - high while the front end is aiming; low clears the repeat count
//   key           - key level, synchronous to clk
//   startOfFrame  - one-cycle pulse per video frame
//   fire          - one-cycle event (combinational from registered state + key):
//                   on the rising edge, then once every REPEAT_FRAMES frames held
module key_repeat
  import shot_pkg::*;
#(
  parameter int REPEAT_FRAMES = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  input  logic key,
  input  logic startOfFrame,
  output logic fire
);

  localparam logic [FRAME_W-1:0] REP_LAST = FRAME_W'(REPEAT_FRAMES - 1);

  logic               key_prev_q;
  logic [FRAME_W-1:0] rep_cnt_q, rep_cnt_d;
  logic               held;
  logic               edge_evt;
  logic               repeat_evt;

  assign held       = key & key_prev_q;
  assign edge_evt   = enable & key & ~key_prev_q;
  // The press edge itself is not a counted frame; repeats count frames after it.
  assign repeat_evt = enable & held & startOfFrame & (rep_cnt_q == REP_LAST);
  assign fire       = edge_evt | repeat_evt;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (!enable || !key) begin
      rep_cnt_d = '0;
    end else if (held && startOfFrame) begin
      rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_prev_q <= 1'b0;
      rep_cnt_q  <= '0;
    end else begin
      key_prev_q <= key;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/shot_charge_ctrl.sv
// shot_charge_ctrl: keyboard-to-shot front end for the white ball.
// Turns arrow/Enter key levels into single-cycle charge and release pulses,
// aiming only while the ball has been at rest for SETTLE_FRAMES frames.
// Ports:
//   clk, resetN                        - clock, asynchronous active-low reset
//   startOfFrame                       - one-cycle pulse per frame
//   keyUp/Down/Left/Right/Enter        - key levels, synchronous to clk
//   XspeedIN, YspeedIN                 - signed ball speeds from the move block
//   chargeUp/Down/Left/Right           - registered one-cycle charge pulses
//   releaseBall                        - registered one-cycle fire pulse
//   aimX, aimY                         - net charge steps per axis (signed)
//   shotState                          - current FSM state encoding
// Build option: define SHOT_TIMEOUT_EN to auto-release after TIMEOUT_FRAMES
// idle frames in AIM with a nonzero aim level.
module shot_charge_ctrl
  import shot_pkg::*;
#(
  parameter int MAX_STEPS      = 4,
  parameter int REPEAT_FRAMES  = 8,
  parameter int SETTLE_FRAMES  = 4,
  parameter int TIMEOUT_FRAMES = 90
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      keyUp,
  input  logic                      keyDown,
  input  logic                      keyLeft,
  input  logic                      keyRight,
  input  logic                      keyEnter,
  input  logic signed [10:0]        XspeedIN,
  input  logic signed [10:0]        YspeedIN,
  output logic                      chargeUp,
  output logic                      chargeDown,
  output logic                      chargeLeft,
  output logic                      chargeRight,
  output logic                      releaseBall,
  output logic signed [3:0]         aimX,
  output logic signed [3:0]         aimY,
  output logic [1:0]                shotState
);

  localparam logic signed [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(MAX_STEPS);
  localparam logic signed [LEVEL_W-1:0] LVL_MIN    = LEVEL_W'(-MAX_STEPS);
  localparam logic signed [LEVEL_W-1:0] LVL_ONE    = LEVEL_W'(1);
  localparam logic [FRAME_W-1:0]        SETTLE_LIM = FRAME_W'(SETTLE_FRAMES);

  // Frame parameters must fit the 7-bit frame counters or they never terminate.
  if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > (1 << FRAME_W) - 1 ||
      REPEAT_FRAMES < 1 || REPEAT_FRAMES > (1 << FRAME_W) - 1 ||
      TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > (1 << FRAME_W) - 1) begin : g_param_check
    $error("shot_charge_ctrl: frame parameter out of range for frame counters");
  end

  shot_state_t               state_q, state_d;
  logic [FRAME_W-1:0]        settle_q, settle_d;
  logic signed [LEVEL_W-1:0] aim_x_q, aim_x_d;
  logic signed [LEVEL_W-1:0] aim_y_q, aim_y_d;
  logic [3:0]                charge_q, charge_d;   // {right, left, down, up}
  logic                      release_q, release_d;
  logic                      enter_prev_q;

  logic [3:0] arrow_keys;
  logic [3:0] arrow_fire;
  logic       aim_active;
  logic       enter_edge;
  logic       speed_zero;
  logic       levels_nz;
  logic       up_ok, down_ok, left_ok, right_ok;

  assign aim_active = (state_q == AIM);
  assign arrow_keys = {keyRight, keyLeft, keyDown, keyUp};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_arrow
    key_repeat #(
      .REPEAT_FRAMES(REPEAT_FRAMES)
    ) u_key_repeat (
      .clk          (clk),
      .resetN       (resetN),
      .enable       (aim_active),
      .key          (arrow_keys[gi]),
      .startOfFrame (startOfFrame),
      .fire         (arrow_fire[gi])
    );
  end

  assign enter_edge = keyEnter & ~enter_prev_q;
  assign speed_zero = (XspeedIN == '0) && (YspeedIN == '0);
  assign levels_nz  = (aim_x_q != '0) || (aim_y_q != '0);

  // Opposing events on one axis cancel; the limit gate keeps levels from wrapping.
  assign up_ok    = arrow_fire[0] & ~arrow_fire[1] & (aim_y_q < LVL_MAX);
  assign down_ok  = arrow_fire[1] & ~arrow_fire[0] & (aim_y_q > LVL_MIN);
  assign left_ok  = arrow_fire[2] & ~arrow_fire[3] & (aim_x_q < LVL_MAX);
  assign right_ok = arrow_fire[3] & ~arrow_fire[2] & (aim_x_q > LVL_MIN);

`ifdef SHOT_TIMEOUT_EN
  logic [FRAME_W-1:0] timeout_q, timeout_d;
  logic               key_active;
  localparam logic [FRAME_W-1:0] TIMEOUT_LIM = FRAME_W'(TIMEOUT_FRAMES);
  assign key_active = (|arrow_keys) | keyEnter;
`endif

  always_comb begin
    state_d   = state_q;
    settle_d  = '0;
    aim_x_d   = aim_x_q;
    aim_y_d   = aim_y_q;
    charge_d  = '0;
    release_d = 1'b0;
`ifdef SHOT_TIMEOUT_EN
    timeout_d = '0;
`endif
    case (state_q)
      IDLE: begin
        settle_d = settle_q;
        if (!speed_zero) begin
          settle_d = '0;
        end else if (startOfFrame) begin
          settle_d = frame_inc_sat(settle_q, SETTLE_LIM);
          if (settle_d == SETTLE_LIM) begin
            state_d  = AIM;
            settle_d = '0;
          end
        end
      end
      AIM: begin
        if (!speed_zero) begin
          // Ball knocked while aiming: abandon the aim.
          aim_x_d = '0;
          aim_y_d = '0;
          state_d = IDLE;
        end else if (enter_edge && levels_nz) begin
          // Release takes priority; any arrow event this cycle is dropped.
          state_d = FIRE;
        end else begin
          charge_d = {right_ok, left_ok, down_ok, up_ok};
          if (up_ok) begin
            aim_y_d = aim_y_q + LVL_ONE;
          end else if (down_ok) begin
            aim_y_d = aim_y_q - LVL_ONE;
          end
          if (left_ok) begin
            aim_x_d = aim_x_q + LVL_ONE;
          end else if (right_ok) begin
            aim_x_d = aim_x_q - LVL_ONE;
          end
`ifdef SHOT_TIMEOUT_EN
          timeout_d = timeout_q;
          if (key_active) begin
            timeout_d = '0;
          end else if (startOfFrame) begin
            timeout_d = frame_inc_sat(timeout_q, TIMEOUT_LIM);
          end
          // With zero levels the counter just parks at its limit.
          if (!key_active && (timeout_d == TIMEOUT_LIM) && levels_nz) begin
            state_d = FIRE;
          end
`endif
        end
      end
      FIRE: begin
        release_d = 1'b1;
        aim_x_d   = '0;
        aim_y_d   = '0;
        state_d   = IDLE;
      end
      default: begin
        aim_x_d = '0;
        aim_y_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      aim_x_q      <= '0;
      aim_y_q      <= '0;
      charge_q     <= '0;
      release_q    <= 1'b0;
      enter_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      aim_x_q      <= aim_x_d;
      aim_y_q      <= aim_y_d;
      charge_q     <= charge_d;
      release_q    <= release_d;
      enter_prev_q <= keyEnter;
    end
  end

`ifdef SHOT_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

  assign chargeUp    = charge_q[0];
  assign chargeDown  = charge_q[1];
  assign chargeLeft  = charge_q[2];
  assign chargeRight = charge_q[3];
  assign releaseBall = release_q;
  assign aimX        = aim_x_q;
  assign aimY        = aim_y_q;
  assign shotState   = state_q;

endmodule

// File: tb/tb_shot_charge_ctrl.sv
// Testbench for shot_charge_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model.
module tb_shot_charge_ctrl;

  localparam int MAX_STEPS      = 4;
  localparam int REPEAT_FRAMES  = 8;
  localparam int SETTLE_FRAMES  = 4;
  localparam int TIMEOUT_FRAMES = 90;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  logic keyUp, keyDown, keyLeft, keyRight, keyEnter;
  logic signed [10:0] XspeedIN, YspeedIN;
  logic chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall;
  logic signed [3:0] aimX, aimY;
  logic [1:0] shotState;

  shot_charge_ctrl #(
    .MAX_STEPS(MAX_STEPS), .REPEAT_FRAMES(REPEAT_FRAMES),
    .SETTLE_FRAMES(SETTLE_FRAMES), .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .keyUp(keyUp), .keyDown(keyDown), .keyLeft(keyLeft), .keyRight(keyRight),
    .keyEnter(keyEnter), .XspeedIN(XspeedIN), .YspeedIN(YspeedIN),
    .chargeUp(chargeUp), .chargeDown(chargeDown), .chargeLeft(chargeLeft),
    .chargeRight(chargeRight), .releaseBall(releaseBall),
    .aimX(aimX), .aimY(aimY), .shotState(shotState)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 aim, 2 fire. Counts are plain integers.
  int         m_mode, m_settle, m_ax, m_ay, m_idle;
  int         m_held[4];
  logic [4:0] m_prev;
  logic [3:0] e_chg;
  logic       e_rel;

  task automatic model_reset();
    m_mode = 0; m_settle = 0; m_ax = 0; m_ay = 0; m_idle = 0;
    for (int i = 0; i < 4; i++) m_held[i] = 0;
    m_prev = '0; e_chg = '0; e_rel = 1'b0;
  endtask

  // k = {enter, right, left, down, up}
  task automatic model_step(input logic [4:0] k, input int x, input int y, input bit f);
    bit ev[4];
    bit moving;
    bit enter_edge;
    moving     = (x != 0) || (y != 0);
    enter_edge = k[4] && !m_prev[4];
    for (int i = 0; i < 4; i++) begin
      ev[i] = 1'b0;
      if (m_mode == 1 && k[i]) begin
        if (!m_prev[i]) begin
          ev[i] = 1'b1;
          m_held[i] = 0;
        end else if (f) begin
          m_held[i]++;
          if (m_held[i] % REPEAT_FRAMES == 0) ev[i] = 1'b1;
        end
      end else begin
        m_held[i] = 0;
      end
    end
    e_chg = '0;
    e_rel = 1'b0;
    case (m_mode)
      0: begin
        if (moving) m_settle = 0;
        else if (f) begin
          m_settle++;
          if (m_settle >= SETTLE_FRAMES) begin
            m_mode = 1;
            m_settle = 0;
          end
        end
      end
      1: begin
        if (moving) begin
          m_ax = 0; m_ay = 0; m_mode = 0; m_idle = 0;
        end else if (enter_edge && (m_ax != 0 || m_ay != 0)) begin
          m_mode = 2; m_idle = 0;
        end else begin
          if (ev[0] && !ev[1] && m_ay < MAX_STEPS)  begin e_chg[0] = 1'b1; m_ay++; end
          if (ev[1] && !ev[0] && m_ay > -MAX_STEPS) begin e_chg[1] = 1'b1; m_ay--; end
          if (ev[2] && !ev[3] && m_ax < MAX_STEPS)  begin e_chg[2] = 1'b1; m_ax++; end
          if (ev[3] && !ev[2] && m_ax > -MAX_STEPS) begin e_chg[3] = 1'b1; m_ax--; end
`ifdef SHOT_TIMEOUT_EN
          if (k != 0) m_idle = 0;
          else if (f && m_idle < TIMEOUT_FRAMES) m_idle++;
          if (k == 0 && m_idle == TIMEOUT_FRAMES && (m_ax != 0 || m_ay != 0)) begin
            m_mode = 2; m_idle = 0;
          end
`endif
        end
      end
      default: begin
        e_rel = 1'b1; m_ax = 0; m_ay = 0; m_mode = 0;
      end
    endcase
    m_prev = k;
  endtask

  // ---------------- stimulus helpers ----------------
  int n_up, n_rel, n_any_before, n_wide;
  logic prev_up, prev_rel;

  task automatic set_keys(input logic [4:0] k);
    {keyEnter, keyRight, keyLeft, keyDown, keyUp} = k;
  endtask

  task automatic cyc(input bit f);
    startOfFrame = f;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    n_up  += int'(chargeUp);
    n_rel += int'(releaseBall);
    n_any_before += int'(chargeUp | chargeDown | chargeLeft | chargeRight | releaseBall);
    if ((chargeUp && prev_up) || (releaseBall && prev_rel)) n_wide++;
    prev_up  = chargeUp;
    prev_rel = releaseBall;
  endtask

  task automatic frame();
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    set_keys('0);
    XspeedIN = '0; YspeedIN = '0; startOfFrame = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetN = 1'b1;
    n_up = 0; n_rel = 0; n_any_before = 0; n_wide = 0;
    prev_up = 1'b0; prev_rel = 1'b0;
    model_reset();
  endtask

  task automatic settle_to_aim(input string tag);
    for (int fr = 1; fr <= SETTLE_FRAMES; fr++) begin
      cyc(1'b1);
      if (fr == SETTLE_FRAMES - 1 || fr == SETTLE_FRAMES)
        check($sformatf("%s state@frame%0d", tag, fr), int'(shotState), (fr == SETTLE_FRAMES) ? 1 : 0);
      cyc(1'b0); cyc(1'b0); cyc(1'b0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] keys;   // {enter, right, left, down, up}
    int         xs;
    int         ys;
    bit         sof;
    logic [3:0] chg;    // {right, left, down, up}
    bit         rel;
    int         ax;
    int         ay;
    int         st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] k, input int xs, input int ys, input bit f,
                     input logic [3:0] chg, input bit rel, input int ax, input int ay, input int st);
    vec_t v;
    v.keys = k; v.xs = xs; v.ys = ys; v.sof = f;
    v.chg = chg; v.rel = rel; v.ax = ax; v.ay = ay; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    // settle, then aim
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 1);
    add(5'b00001, 0, 0, 1, 4'b0001, 0, 0, 1, 1);  // up edge
    add(5'b00001, 0, 0, 1, 4'b0000, 0, 0, 1, 1);  // held, no repeat yet
    add(5'b01100, 0, 0, 0, 4'b0000, 0, 0, 1, 1);  // left+right cancel
    add(5'b00000, 0, 0, 0, 4'b0000, 0, 0, 1, 1);
    add(5'b00101, 0, 0, 0, 4'b0101, 0, 1, 2, 1);  // up+left both
    add(5'b00000, 0, 0, 0, 4'b0000, 0, 1, 2, 1);
    add(5'b00010, 0, 0, 0, 4'b0010, 0, 1, 1, 1);  // down
    add(5'b11000, 0, 0, 0, 4'b0000, 0, 1, 1, 2);  // enter wins over right
    add(5'b11000, 0, 0, 0, 4'b0000, 1, 0, 0, 0);  // fire cycle
    add(5'b00000, 5, 0, 1, 4'b0000, 0, 0, 0, 0);  // moving clears settle
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 1, 4'b0000, 0, 0, 0, 1);
    add(5'b10000, 0, 0, 0, 4'b0000, 0, 0, 0, 1);  // enter with zero levels ignored
    add(5'b00100, 0, 0, 0, 4'b0100, 0, 1, 0, 1);
    add(5'b00000, 0, -3, 0, 4'b0000, 0, 0, 0, 0); // knocked while aiming
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] rk;
    int mv_left;
    int rx;

    do_reset();
    // reset values (taken again while held in reset)
    resetN = 1'b0;
    #2;
    check("reset chargeUp", int'(chargeUp), 0);
    check("reset release", int'(releaseBall), 0);
    check("reset aimX", int'(aimX), 0);
    check("reset aimY", int'(aimY), 0);
    check("reset state", int'(shotState), 0);
    resetN = 1'b1;

    // vector table
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_keys(tbl[i].keys);
      XspeedIN = 11'(tbl[i].xs);
      YspeedIN = 11'(tbl[i].ys);
      startOfFrame = tbl[i].sof;
      @(posedge clk); #1;
      check($sformatf("vec%0d charge", i), int'({chargeRight, chargeLeft, chargeDown, chargeUp}), int'(tbl[i].chg));
      check($sformatf("vec%0d release", i), int'(releaseBall), int'(tbl[i].rel));
      check($sformatf("vec%0d aimX", i), int'(aimX), tbl[i].ax);
      check($sformatf("vec%0d aimY", i), int'(aimY), tbl[i].ay);
      check($sformatf("vec%0d state", i), int'(shotState), tbl[i].st);
    end

    // sequence A: settle, then hold up for 40 frames
    do_reset();
    settle_to_aim("seqA");
    check("seqA no pulses before aim", n_any_before, 0);
    n_up = 0;
    keyUp = 1'b1;
    for (int fr = 0; fr < 40; fr++) frame();
    check("seqA up pulses", n_up, 4);
    check("seqA aimY saturated", int'(aimY), MAX_STEPS);
    keyUp = 1'b0;
    cyc(1'b0);

    // sequence B: aimY=2, Enter edge, release latency, then settle after motion
    repeat (2) begin
      keyDown = 1'b1; cyc(1'b0);
      keyDown = 1'b0; cyc(1'b0);
    end
    check("seqB aimY", int'(aimY), 2);
    keyEnter = 1'b1;
    cyc(1'b0);
    check("seqB rel cycle1", int'(releaseBall), 0);
    check("seqB state fire", int'(shotState), 2);
    cyc(1'b0);
    check("seqB rel cycle2", int'(releaseBall), 1);
    check("seqB aimY cleared", int'(aimY), 0);
    check("seqB state idle", int'(shotState), 0);
    keyEnter = 1'b0;
    cyc(1'b0);
    check("seqB rel width", int'(releaseBall), 0);
    YspeedIN = 11'sd400;
    for (int fr = 0; fr < 50; fr++) frame();
    check("seqB moving idle", int'(shotState), 0);
    YspeedIN = '0;
    settle_to_aim("seqB");
    check("seqB pulse width", n_wide, 0);

    // sequence C: Enter with zero levels, then knock the ball while aiming
    n_rel = 0;
    keyEnter = 1'b1; cyc(1'b0); cyc(1'b0);
    keyEnter = 1'b0; cyc(1'b0);
    check("seqC no release", n_rel, 0);
    check("seqC still aim", int'(shotState), 1);
    keyLeft = 1'b1; cyc(1'b0);
    keyLeft = 1'b0; cyc(1'b0);
    check("seqC aimX", int'(aimX), 1);
    XspeedIN = 11'sd5; cyc(1'b0);
    check("seqC knocked state", int'(shotState), 0);
    check("seqC knocked aimX", int'(aimX), 0);
    XspeedIN = '0;

    // sequence D: aimX=-1, no keys for 200 frames
    settle_to_aim("seqD");
    keyRight = 1'b1; cyc(1'b0);
    keyRight = 1'b0; cyc(1'b0);
    check("seqD aimX", int'(aimX), -1);
    n_rel = 0;
    for (int fr = 0; fr < 200; fr++) frame();
`ifdef SHOT_TIMEOUT_EN
    check("seqD timeout release", n_rel, 1);
    check("seqD aimX cleared", int'(aimX), 0);
`else
    check("seqD no timeout release", n_rel, 0);
    check("seqD aimX kept", int'(aimX), -1);
`endif

    // randomized run against the reference model
    do_reset();
    rk = '0;
    mv_left = 0;
    rx = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 7) == 0) rk[j] = ~rk[j];
      if ($urandom_range(0, 15) == 0) rk[4] = ~rk[4];
      if (mv_left > 0) begin
        mv_left--;
      end else begin
        rx = 0;
        if ($urandom_range(0, 99) == 0) begin
          mv_left = int'($urandom_range(1, 6));
          rx = int'($urandom_range(1, 500)) - 250;
          if (rx == 0) rx = 7;
        end
      end
      set_keys(rk);
      XspeedIN = 11'(rx);
      YspeedIN = '0;
      startOfFrame = (i % 3 == 0);
      model_step(rk, rx, 0, i % 3 == 0);
      @(posedge clk); #1;
      check($sformatf("rnd%0d charge", i), int'({chargeRight, chargeLeft, chargeDown, chargeUp}), int'(e_chg));
      check($sformatf("rnd%0d release", i), int'(releaseBall), int'(e_rel));
      check($sformatf("rnd%0d aimX", i), int'(aimX), m_ax);
      check($sformatf("rnd%0d aimY", i), int'(aimY), m_ay);
      check($sformatf("rnd%0d state", i), int'(shotState), m_mode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_charge_ctrl.md
# shot_charge_ctrl

Keyboard-to-shot front end for the white ball. Converts raw key levels (arrows, Enter) into the single-cycle `chargeUp/Down/Left/Right` and `releaseBall` pulses consumed by the white-ball move/collision block. Gates aiming on the ball being at rest, as reported by that block's `XspeedOUT`/`YspeedOUT`. Also exports the net aim level per axis for the on-screen cue-strength indicator.

## Interface
Parameters:
- `MAX_STEPS`, 4: net charge limit per axis, in steps of one pulse; matches downstream 800/200.
- `REPEAT_FRAMES`, 8: frames between auto-repeat pulses while an arrow is held.
- `SETTLE_FRAMES`, 4: consecutive zero-speed frames required before aiming is allowed.
- `TIMEOUT_FRAMES`, 90: idle-aim frames before auto-release (only with `SHOT_TIMEOUT_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `keyUp`, `keyDown`, `keyLeft`, `keyRight`, `keyEnter` in 1 each: key levels, already synchronous to `clk`.
- `XspeedIN`, `YspeedIN` in signed 11: white-ball speeds from the move/collision block.
- `chargeUp`, `chargeDown`, `chargeLeft`, `chargeRight` out 1: one-cycle charge pulses.
- `releaseBall` out 1: one-cycle fire pulse.
- `aimX`, `aimY` out signed 4: net charge steps, range −MAX_STEPS..+MAX_STEPS.
- `shotState` out 2: current FSM state encoding.

## Operation
FSM states:
- **IDLE**, reset state. The settle counter counts frames with `XspeedIN==0 && YspeedIN==0`. Any nonzero speed clears it. When it reaches SETTLE_FRAMES, go to AIM.
- **AIM**. Arrow handling:
  - A rising edge emits a pulse on the next cycle.
  - While the key stays held, one further pulse every REPEAT_FRAMES `startOfFrame` pulses.
- **AIM, limits and counters**:
  - `chargeUp` is emitted only if `aimY < MAX_STEPS`; `aimY` then increments.
  - `chargeDown` is emitted only if `aimY > −MAX_STEPS`; `aimY` then decrements.
  - Left/right do the same on `aimX`, with left incrementing.
  - A suppressed pulse does not change the counter.
- **AIM, exits**:
  - Enter rising edge with `aimX != 0 || aimY != 0` goes to FIRE.
  - Enter with both levels zero is ignored.
  - Any nonzero input speed while in AIM clears `aimX`/`aimY` and goes to IDLE.
- **FIRE**. Lasts one cycle. `releaseBall` = 1. `aimX`/`aimY` clear, then go to IDLE.

Simultaneous events:
- Up and down in the same cycle: both suppressed. Same rule for left and right.
- Orthogonal pulses in the same cycle (e.g. up + left) are both allowed.
- Enter edge in the same cycle as an arrow event: release wins and the arrow event is dropped.
- Repeat counters reset on key release and on leaving AIM.

Arithmetic:
- Level counters are signed 4-bit and saturate by the gating rule, so they never wrap.
- Frame counters are 7-bit unsigned and saturate at their terminal count.

Reset mid-operation: all state returns to IDLE with counters zero, including during FIRE; the downstream block is reset independently.

## Timing
- Reset values: all pulse outputs 0; `aimX = aimY = 0`; `shotState` = IDLE.
- All outputs are registered.
- Key edge to charge pulse: 1 cycle. Enter edge to `releaseBall`: 2 cycles (AIM→FIRE transition, then FIRE output).
- Pulse width is exactly 1 `clk`. Pulses never occur outside AIM/FIRE, so the downstream zero-speed gate is always true when a pulse arrives.
- After FIRE the downstream speed becomes nonzero one cycle later. IDLE therefore sees movement and re-arms only after the ball stops plus SETTLE_FRAMES frames.

## Configuration
- `SHOT_TIMEOUT_EN` defined: in AIM, a frame counter counts frames with no arrow or Enter activity. At TIMEOUT_FRAMES with a nonzero level, go to FIRE. At TIMEOUT_FRAMES with both levels zero, the counter holds.
- Any key activity clears the timeout counter.
- Undefined: no timeout logic; release occurs only on Enter.

## Structure
- Package `shot_pkg`: state enum `shot_state_t` (IDLE=0, AIM=1, FIRE=2), level width constant, frame-counter width constant.
- Sub-module `key_repeat`, instantiated four times (once per arrow), contains:
  - edge detect;
  - REPEAT_FRAMES counter;
  - an `enable` input driven by state==AIM;
  - a one-cycle `fire` output.
- Enter uses edge detect only.

## Test plan
- Reset, speeds 0, 4 frames → `shotState` = AIM at the 4th frame; all outputs 0 before that.
- In AIM, hold `keyUp` 40 frames (REPEAT_FRAMES=8) → 4 `chargeUp` pulses (edge + 3 repeats), `aimY` = 4, later repeats suppressed.
- `keyLeft` and `keyRight` rising in the same cycle → no pulse, `aimX` unchanged. `keyUp` + `keyLeft` together → both pulses, `aimX` = `aimY` = 1.
- `aimY` = 2, Enter edge → `releaseBall` 1 cycle, 2 cycles later; levels 0; state IDLE. Drive `YspeedIN` = 400 for 50 frames then 0 → AIM after 4 more frames.
- In AIM, Enter with levels 0 → no release. Drive `XspeedIN` = 5 → IDLE with levels cleared.
- With `SHOT_TIMEOUT_EN`, `aimX` = −1, no keys for 90 frames → `releaseBall` pulse. Without the macro, no pulse after 200 frames.
